alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_result_reg.sv | 87 ++++++++
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer: the 4-bit opcode encoding seen by
// the downstream ALU, the sequencer FSM state encoding and the highest legal
// opcode value.
// ---------------------------------------------------------------------------
package alu_pkg;

   // Opcodes understood by the downstream ALU; anything above OP_RSR is illegal
   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_NOT_A = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_LSL_A = 4'd6,
      OP_LSL   = 4'd7,
      OP_RSR_A = 4'd8,
      OP_RSR   = 4'd9
   } alu_op_e;

   // Sequencer states: wait for a request, let the ALU settle, present result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   localparam int SEL_MAX = 9;

   // True when an incoming opcode is one the ALU implements
   function automatic logic sel_is_legal(input logic [3:0] sel);
      return sel <= 4'(SEL_MAX);
   endfunction

endpackage

// File: rtl/alu_result_reg.sv
// ---------------------------------------------------------------------------
// alu_result_reg
// Capture register for the ALU result and flags presented to the consumer.
// Either loads the live ALU outputs (legal op) or an error record (illegal
// op: result and flags zero, err set); otherwise holds its contents.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cap_alu                  load alu_result/flags, clear err
//   cap_err                  load error record
//   alu_result, alu_cout,
//   alu_neg, alu_zero        combinational ALU outputs
//   out_result, out_cout,
//   out_neg, out_zero,
//   out_err                  captured values
// ---------------------------------------------------------------------------
module alu_result_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap_alu,
   input  logic             cap_err,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             alu_neg,
   input  logic             alu_zero,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_neg,
   output logic             out_zero,
   output logic             out_err
);

   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             neg_q, neg_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   // Hold by default; the two capture requests are mutually exclusive in the
   // sequencer, ALU capture is given priority anyway
   always_comb begin
      result_d = result_q;
      cout_d   = cout_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      err_d    = err_q;
      if (cap_alu) begin
         result_d = alu_result;
         cout_d   = alu_cout;
         neg_d    = alu_neg;
         zero_d   = alu_zero;
         err_d    = 1'b0;
      end else if (cap_err) begin
         result_d = '0;
         cout_d   = 1'b0;
         neg_d    = 1'b0;
         zero_d   = 1'b0;
         err_d    = 1'b1;
      end
   end

   // Capture register, cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         cout_q   <= cout_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign out_result = result_q;
   assign out_cout   = cout_q;
   assign out_neg    = neg_q;
   assign out_zero   = zero_q;
   assign out_err    = err_q;

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Accepts one ALU request at a time, registers the operands towards an
// external combinational ALU, captures its result one cycle later and holds
// it for the consumer until it is accepted. Illegal opcodes skip the ALU and
// produce an error record directly. A wrapping counter tracks completed
// output handshakes.
//
// Configuration macro: ALU_SEQUENCER_ACC_EN
//   defined   -> an accumulator holds the last legal result; requests with
//                in_acc=1 use it as operand a
//   undefined -> no accumulator, in_acc ignored
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              request handshake
//   in_a, in_b, in_sel, in_acc     operands, opcode, accumulator select
//   alu_a, alu_b, alu_sel          registered operands/opcode to the ALU
//   alu_result, alu_cout,
//   alu_neg, alu_zero              combinational ALU outputs
//   out_valid/out_ready            result handshake
//   out_result, out_cout, out_neg,
//   out_zero, out_err              captured result and flags
//   op_count                       completed-operation counter (wraps)
// ---------------------------------------------------------------------------
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_sel,
   input  logic             in_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             alu_neg,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_neg,
   output logic             out_zero,
   output logic             out_err,
   output logic [7:0]       op_count
);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_sel_q, alu_sel_d;
   logic [7:0]       op_count_q, op_count_d;
   logic             cap_alu, cap_err;
   logic             handshake;
   logic [WIDTH-1:0] a_src;

`ifdef ALU_SEQUENCER_ACC_EN
   logic [WIDTH-1:0] acc_q, acc_d;

   // Operand a comes from the accumulator when the request asks for it
   assign a_src = in_acc ? acc_q : in_a;

   // The accumulator follows every legal result the consumer accepts; error
   // records leave it untouched
   always_comb begin
      acc_d = acc_q;
      if (handshake && !out_err) begin
         acc_d = out_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   logic acc_sel_unused;

   assign a_src          = in_a;
   assign acc_sel_unused = in_acc;
`endif

   // Consumer accepts the held result this cycle
   assign handshake = (state_q == ST_DONE) && out_ready;

   // Next-state logic: operand registers load only on acceptance of a legal
   // request so the ALU sees stable inputs through EXEC and afterwards
   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      op_count_d = op_count_q;
      cap_alu    = 1'b0;
      cap_err    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (sel_is_legal(in_sel)) begin
                  alu_a_d   = a_src;
                  alu_b_d   = in_b;
                  alu_sel_d = in_sel;
                  state_d   = ST_EXEC;
               end else begin
                  cap_err = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_EXEC: begin
            cap_alu = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               op_count_d = op_count_q + 8'd1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and operand registers; reset abandons any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         op_count_q <= op_count_d;
      end
   end

   alu_result_reg #(
      .WIDTH (WIDTH)
   ) u_result_reg (
      .clk        (clk),
      .rst        (rst),
      .cap_alu    (cap_alu),
      .cap_err    (cap_err),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .alu_neg    (alu_neg),
      .alu_zero   (alu_zero),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_neg    (out_neg),
      .out_zero   (out_zero),
      .out_err    (out_err)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Testbench for alu_sequencer (WIDTH=4). Provides a behavioural ALU on the
// alu_* port, drives directed and random requests and compares every
// observable against a transaction-level model of the sequencer.
// Honours ALU_SEQUENCER_ACC_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [3:0]   in_sel;
   logic         in_acc;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_sel;
   logic [W-1:0] alu_result;
   logic         alu_cout;
   logic         alu_neg;
   logic         alu_zero;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_cout;
   logic         out_neg;
   logic         out_zero;
   logic         out_err;
   logic [7:0]   op_count;

   int vectors;
   int miscompares;

   // Transaction-level model state
   int           model_count;
   logic [W-1:0] model_acc;
   logic [W-1:0] last_a;
   logic [W-1:0] last_b;
   logic [3:0]   last_sel;

   alu_sequencer #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sel     (in_sel),
      .in_acc     (in_acc),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .alu_neg    (alu_neg),
      .alu_zero   (alu_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_neg    (out_neg),
      .out_zero   (out_zero),
      .out_err    (out_err),
      .op_count   (op_count)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: returns {cout, neg, zero, result}. Subtraction yields
   // the magnitude with neg marking a negative difference.
   function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] sel);
      logic [4:0] wide;
      logic [3:0] r;
      logic       c;
      logic       n;
      wide = '0;
      r    = '0;
      c    = 1'b0;
      n    = 1'b0;
      case (sel)
         4'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[3:0];
            c    = wide[4];
         end
         4'd1: begin
            if (a >= b) r = a - b;
            else begin
               r = b - a;
               n = 1'b1;
            end
         end
         4'd2: r = ~a;
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: begin
            r = {a[2:0], 1'b0};
            c = a[3];
         end
         4'd7: r = a << b;
         4'd8: r = {a[3], a[3:1]};
         4'd9: r = a >> b;
         default: r = '0;
      endcase
      return {c, n, (r == 4'd0), r};
   endfunction

   // The ALU stub the sequencer drives
   always_comb begin
      {alu_cout, alu_neg, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_sel);
   end

   // Overall time limit
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_out_result"}, 32'(out_result), 32'd0);
      checkOutput({tag, "_flags"}, 32'({out_cout, out_neg, out_zero, out_err}), 32'd0);
      checkOutput({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      checkOutput({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      checkOutput({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
      checkOutput({tag, "_op_count"}, 32'(op_count), 32'd0);
   endtask

   task automatic clearModel();
      model_count = 0;
      model_acc   = '0;
      last_a      = '0;
      last_b      = '0;
      last_sel    = '0;
   endtask

   task automatic applyReset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      stepClock();
      stepClock();
      rst = 1'b0;
      clearModel();
      checkResetOutputs("reset");
   endtask

   // One complete request/response transaction with hold cycles in DONE
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] sel, input logic acc, input int hold);
      logic         legal;
      logic [W-1:0] eff_a;
      logic [6:0]   exp;
      logic         exp_err;
      int           lat;

      legal = (sel <= 4'd9);
`ifdef ALU_SEQUENCER_ACC_EN
      eff_a = acc ? model_acc : a;
`else
      eff_a = a;
`endif
      if (legal) begin
         exp     = alu_ref(eff_a, b, sel);
         exp_err = 1'b0;
         last_a   = eff_a;
         last_b   = b;
         last_sel = sel;
      end else begin
         exp     = '0;
         exp_err = 1'b1;
      end

      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sel   = sel;
      in_acc   = acc;
      stepClock();
      in_valid = 1'b0;
      in_a     = 4'($urandom_range(0, 15));
      in_b     = 4'($urandom_range(0, 15));
      lat = 1;
      if (legal) begin
         checkOutput("exec_out_valid", 32'(out_valid), 32'd0);
         checkOutput("exec_in_ready", 32'(in_ready), 32'd0);
         checkOutput("exec_alu_a", 32'(alu_a), 32'(eff_a));
         checkOutput("exec_alu_b", 32'(alu_b), 32'(b));
         checkOutput("exec_alu_sel", 32'(alu_sel), 32'(sel));
      end
      while (!out_valid && lat < 8) begin
         stepClock();
         lat++;
      end
      checkOutput("latency", 32'(lat), legal ? 32'd2 : 32'd1);

      // Hold in DONE while presenting ignored requests
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) stepClock();
         checkOutput("done_out_valid", 32'(out_valid), 32'd1);
         checkOutput("done_in_ready", 32'(in_ready), 32'd0);
         checkOutput("done_result", 32'(out_result), 32'(exp[3:0]));
         checkOutput("done_flags", 32'({out_cout, out_neg, out_zero}), 32'(exp[6:4]));
         checkOutput("done_err", 32'(out_err), 32'(exp_err));
         checkOutput("done_alu_hold", 32'({alu_sel, alu_b, alu_a}),
                     32'({last_sel, last_b, last_a}));
         checkOutput("done_op_count", 32'(op_count), 32'(model_count));
         in_valid = 1'($urandom_range(0, 1));
         in_sel   = 4'($urandom_range(0, 15));
         in_acc   = 1'($urandom_range(0, 1));
      end

      out_ready = 1'b1;
      #1;
      checkOutput("handshake_in_ready", 32'(in_ready), 32'd0);
      stepClock();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      model_count = (model_count + 1) % 256;
      if (legal) model_acc = exp[3:0];
      checkOutput("post_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_in_ready", 32'(in_ready), 32'd1);
      checkOutput("post_op_count", 32'(op_count), 32'(model_count));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = '0;
      in_acc    = 1'b0;
      out_ready = 1'b0;
      clearModel();

      $display("[TB] reset");
      applyReset();

      $display("[TB] directed vectors");
      applyStimulus(4'd5, 4'd3, 4'd0, 1'b0, 0);
      checkOutput("add_5_3", 32'(out_result), 32'd8);
      applyStimulus(4'd9, 4'd8, 4'd0, 1'b0, 1);
      checkOutput("add_9_8_cout", 32'({out_cout, out_result}), 32'h11);
      applyStimulus(4'd3, 4'd5, 4'd1, 1'b0, 0);
      checkOutput("sub_3_5", 32'({out_neg, out_result}), 32'h12);
      applyStimulus(4'd7, 4'd7, 4'd12, 1'b0, 0);
      checkOutput("illegal_err", 32'(out_err), 32'd1);
      applyStimulus(4'd6, 4'd3, 4'd5, 1'b0, 5);
      applyStimulus(4'd4, 4'd4, 4'd1, 1'b0, 0);

`ifdef ALU_SEQUENCER_ACC_EN
      $display("[TB] accumulator");
      applyReset();
      applyStimulus(4'd2, 4'd3, 4'd0, 1'b0, 0);
      applyStimulus(4'd0, 4'd4, 4'd0, 1'b1, 0);
      checkOutput("acc_alu_a", 32'(alu_a), 32'd5);
      checkOutput("acc_result", 32'(out_result), 32'd9);
`endif

      $display("[TB] random vectors");
      for (int n = 0; n < 60; n++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)));
      end

      $display("[TB] reset during EXEC");
      applyStimulus(4'd15, 4'd1, 4'd0, 1'b0, 0);
      in_valid = 1'b1;
      in_a     = 4'd7;
      in_b     = 4'd9;
      in_sel   = 4'd4;
      in_acc   = 1'b0;
      stepClock();
      in_valid = 1'b0;
      checkOutput("pre_rst_in_exec", 32'({in_ready, out_valid}), 32'd0);
      rst = 1'b1;
      stepClock();
      rst = 1'b0;
      clearModel();
      checkResetOutputs("exec_reset");
      stepClock();
      checkOutput("exec_reset_no_done", 32'(out_valid), 32'd0);

      $display("[TB] counter wrap");
      applyReset();
      for (int n = 0; n < 256; n++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
      end
      checkOutput("op_count_wrap", 32'(op_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
